// File: rtl/sram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_arb_pkg
// Description : Shared types and constants for the two-master SRAM arbiter:
//               FSM state encoding, grant identifiers, timer width and the
//               default watchdog / error-data values.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_e;

    localparam logic GNT_M0 = 1'b0;
    localparam logic GNT_M1 = 1'b1;

    localparam int TIMER_W = 16;

    localparam int unsigned DEF_TIMEOUT   = 255;
    localparam logic [31:0] DEF_ERR_RDATA = 32'hFFFF_FFFF;

endpackage
`default_nettype wire

// File: rtl/sram_arb_timer.sv
`default_nettype none
// ============================================================================
// Module      : sram_arb_timer
// Description : Per-transaction watchdog counter. Synchronous clear, count
//               enable, saturates at all-ones instead of wrapping, and flags
//               when the count equals TIMEOUT.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_arb_timer
    import sram_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic r_clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_hit
);

    localparam logic [TIMER_W-1:0] c_LIMIT = TIMER_W'(TIMEOUT);

    logic [TIMER_W-1:0] r_count;

    // Clear has priority over counting; hold at all-ones once saturated.
    always_ff @(posedge r_clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != {TIMER_W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_hit = (r_count == c_LIMIT);

endmodule
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_arbiter
// Description : Two-master arbiter in front of a single valid/ready memory
//               port. Serialises one transaction at a time through an
//               IDLE -> BUSY -> DONE sequence and aborts a stalled slave via
//               a saturating watchdog, returning ERR_RDATA and pulsing err.
//               Build option: SRAM_ARB_RR_EN selects round-robin arbitration
//               on simultaneous requests; otherwise master 0 has fixed
//               priority.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT   = DEF_TIMEOUT,
    parameter logic [31:0] ERR_RDATA = DEF_ERR_RDATA
) (
    input  logic        r_clk,
    input  logic        rst_n,
    input  logic        m0_valid,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    output logic        grant,
    output logic        err,
    output logic [31:0] err_addr
);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_BUSY = BUSY;
    localparam logic [1:0] S_DONE = DONE;

    logic [1:0]  r_state;
    logic        r_grant;
    logic [31:0] r_s_addr;
    logic [31:0] r_s_wdata;
    logic [3:0]  r_s_wstrb;
    logic [31:0] r_m0_rdata;
    logic [31:0] r_m1_rdata;
    logic        r_err;
    logic [31:0] r_err_addr;

    logic        w_any_req;
    logic        w_pick;
    logic        w_hit;

    assign w_any_req = m0_valid | m1_valid;

`ifdef SRAM_ARB_RR_EN
    // Last-granted master; resets to m1 so that m0 wins the first tie.
    logic r_last_gnt;

    // Record every grant so the next tie goes to the other master.
    always_ff @(posedge r_clk) begin
        if (!rst_n) begin
            r_last_gnt <= GNT_M1;
        end else if ((r_state == S_IDLE) && w_any_req) begin
            r_last_gnt <= w_pick;
        end
    end

    assign w_pick = (m0_valid && m1_valid) ? ~r_last_gnt
                  : (m1_valid ? GNT_M1 : GNT_M0);
`else
    assign w_pick = m0_valid ? GNT_M0 : GNT_M1;
`endif

    sram_arb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .r_clk (r_clk),
        .rst_n (rst_n),
        .i_clr (r_state == S_IDLE),
        .i_en  (r_state == S_BUSY),
        .o_hit (w_hit)
    );

    // Transaction sequencer: latch winner, wait for slave or watchdog, respond.
    always_ff @(posedge r_clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_grant    <= GNT_M0;
            r_s_addr   <= '0;
            r_s_wdata  <= '0;
            r_s_wstrb  <= '0;
            r_m0_rdata <= '0;
            r_m1_rdata <= '0;
            r_err      <= 1'b0;
            r_err_addr <= '0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_grant   <= w_pick;
                        r_s_addr  <= (w_pick == GNT_M1) ? m1_addr  : m0_addr;
                        r_s_wdata <= (w_pick == GNT_M1) ? m1_wdata : m0_wdata;
                        r_s_wstrb <= (w_pick == GNT_M1) ? m1_wstrb : m0_wstrb;
                        r_state   <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    // Slave completion beats the watchdog in the same cycle.
                    if (s_ready) begin
                        if (r_grant == GNT_M1) r_m1_rdata <= s_rdata;
                        else                   r_m0_rdata <= s_rdata;
                        r_state <= S_DONE;
                    end else if (w_hit) begin
                        if (r_grant == GNT_M1) r_m1_rdata <= ERR_RDATA;
                        else                   r_m0_rdata <= ERR_RDATA;
                        r_err      <= 1'b1;
                        r_err_addr <= r_s_addr;
                        r_state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign s_valid  = (r_state == S_BUSY);
    assign s_addr   = r_s_addr;
    assign s_wdata  = r_s_wdata;
    assign s_wstrb  = r_s_wstrb;
    assign m0_ready = (r_state == S_DONE) && (r_grant == GNT_M0);
    assign m1_ready = (r_state == S_DONE) && (r_grant == GNT_M1);
    assign m0_rdata = r_m0_rdata;
    assign m1_rdata = r_m1_rdata;
    assign grant    = r_grant;
    assign err      = r_err;
    assign err_addr = r_err_addr;

endmodule
`default_nettype wire

// File: doc/sram_arbiter.md
# sram_arbiter

Two-master arbiter sharing one native valid/ready memory port between the picorv32 core (master 0) and a second bus master (master 1, e.g. the recovery/boot loader DMA). It sits between the masters and the SRAM/MMIO decode logic and serialises transactions one at a time. A per-transaction watchdog aborts a stalled slave, so a hung peripheral cannot deadlock the SoC.

## Interface
- TIMEOUT, 255: slave cycles allowed in BUSY before abort; range 1..65535.
- ERR_RDATA, 32'hFFFF_FFFF: read data returned on an aborted transaction.
- r_clk  in  1  system clock.
- rst_n  in  1  reset; synchronous, active-low; clock r_clk.
- m0_valid / m1_valid  in  1  master request.
- m0_addr / m1_addr  in  32  byte address.
- m0_wdata / m1_wdata  in  32  write data.
- m0_wstrb / m1_wstrb  in  4  byte strobes; 0 = read.
- m0_ready / m1_ready  out  1  one-cycle completion pulse.
- m0_rdata / m1_rdata  out  32  read data, valid while the matching ready is high.
- s_valid  out  1  request to the slave.
- s_addr, s_wdata  out  32  latched request.
- s_wstrb  out  4  latched strobes.
- s_ready  in  1  slave completion.
- s_rdata  in  32  slave read data.
- grant  out  1  owner of the current or last transaction (0 = m0).
- err  out  1  one-cycle pulse on timeout abort.
- err_addr  out  32  address of the most recent aborted transaction; sticky until reset.

## Operation
- FSM states:
  - IDLE: if any mX_valid is high, select a winner, latch its addr/wdata/wstrb into s_*, set grant, clear the timer, and go to BUSY.
  - BUSY: hold s_valid=1 and keep s_* stable; increment the timer each cycle.
    - s_ready=1: capture s_rdata, drop s_valid, go to DONE.
    - Otherwise, timer==TIMEOUT: drop s_valid, load ERR_RDATA, pulse err, write err_addr, go to DONE.
  - DONE: assert the granted mX_ready for exactly one cycle with mX_rdata, then go to IDLE.
- mX_rdata holds its last value between transactions. The ungranted master's ready stays 0.
- A master must hold valid and its payload until it sees ready. Requests are sampled only in IDLE, so a master that drops valid before being granted loses no state.
- A write response also drives rdata, with the captured s_rdata value; masters ignore it.
- s_ready while not in BUSY is ignored.
- If s_ready and timer==TIMEOUT occur in the same cycle, s_ready wins: normal completion, no err.
- The timer is 16 bits and saturates; it never wraps.
- Reset, including mid-transaction: the next state is IDLE, and all outputs are 0 except mX_rdata and err_addr, which are also 0. The in-flight transaction is dropped with no ready pulse.

## Timing
- Request visible at edge N in IDLE: s_valid=1 after edge N.
- s_ready sampled at edge N+k: mX_ready=1 during cycle N+k+1.
- Next grant is evaluated at edge N+k+2.
- Minimum turnaround is 3 cycles per transaction with a one-cycle slave.
- Abort: err and mX_ready pulse one cycle after the edge where the timer reaches TIMEOUT, i.e. TIMEOUT+2 cycles after the grant.
- The DONE cycle guarantees the granted master's valid is low (or already a new request) by IDLE, so it can never be double-granted.

## Configuration
- SRAM_ARB_RR_EN defined: round-robin. On a simultaneous request, the master not granted last wins. The reset value of the last-grant state is 1, so m0 wins the first tie.
- SRAM_ARB_RR_EN undefined: fixed priority, m0 always wins. m1 can starve under continuous m0 traffic, which is acceptable for the core-first boot flow.

## Structure
- Shared package sram_arb_pkg:
  - state enum {IDLE, BUSY, DONE};
  - grant constants GNT_M0=0, GNT_M1=1;
  - TIMER_W=16;
  - default TIMEOUT and ERR_RDATA constants.
- One sub-module, sram_arb_timer: a clear/enable/saturating 16-bit counter with a compare-equal output against TIMEOUT.

## Test plan
- m0 read addr 0x100, slave returns 0xDEADBEEF after 1 cycle -> m0_ready pulses 1 cycle with rdata 0xDEADBEEF; grant=0; m1_ready stays 0.
- m0 and m1 request in the same cycle, 4 back-to-back transactions:
  - with SRAM_ARB_RR_EN -> grants 0,1,0,1;
  - without -> 0,0,0,0 while m1 stays pending.
- m1 write 0x01000004 wstrb 4'b0001, slave never readies, TIMEOUT=8 -> err and m1_ready pulse together 10 cycles after grant; m1_rdata=0xFFFFFFFF; err_addr=0x01000004.
- s_ready asserted on the same cycle the timer hits TIMEOUT -> normal completion with slave data; err stays 0.
- rst_n low for 1 cycle while in BUSY -> s_valid=0 next cycle, no mX_ready pulse, err_addr=0, FSM in IDLE; the next request completes normally.
- Random traffic, 10k transactions, slave latency 1..20 -> every request gets exactly one ready pulse; the s_* payload matches the granted master; no overlapping s_valid transactions.
